// File: rtl/sdma_sap_upsample_scanner.sv
// Raster-order position sequencer for the SAP upsample/padding write path.
// Optional abort input/output pair enabled by defining SDMA_SAP_US_ABORT_EN.
module sdma_sap_upsample_scanner #(
    parameter int ZNUMW = 4,
    parameter int DIMW  = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sap_us_start,
    input  logic             i_sap_us_upsampleen,
    input  logic             i_sap_us_paddingen,
    input  logic [ZNUMW-1:0] i_sap_us_insertzeronum,
    input  logic [ZNUMW-1:0] i_sap_us_upsampleidxx,
    input  logic [ZNUMW-1:0] i_sap_us_upsampleidxy,
    input  logic [DIMW-1:0]  i_sap_us_padtop,
    input  logic [DIMW-1:0]  i_sap_us_padbottom,
    input  logic [DIMW-1:0]  i_sap_us_padleft,
    input  logic [DIMW-1:0]  i_sap_us_padright,
    input  logic [DIMW-1:0]  i_sap_us_corewidth,
    input  logic [DIMW-1:0]  i_sap_us_coreheight,
`ifdef SDMA_SAP_US_ABORT_EN
    input  logic             i_sap_us_abort,
    output logic             o_sap_us_aborted,
`endif
    output logic             o_sap_us_vld,
    input  logic             i_sap_us_rdy,
    output logic [DIMW-1:0]  o_sap_us_x,
    output logic [DIMW-1:0]  o_sap_us_y,
    output logic             o_sap_us_paddingflag,
    output logic             o_sap_us_upsampleflag,
    output logic             o_sap_us_last,
    output logic             o_sap_us_busy,
    output logic             o_sap_us_done
);
    localparam int SW = DIMW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    state_t           state_reg;
    logic             vld_reg, busy_reg, done_reg;
    logic             us_en_reg;
    logic [ZNUMW-1:0] nz_reg, idx_x_reg, idx_y_reg, xcnt_reg, ycnt_reg;
    logic [DIMW-1:0]  pad_top_reg, pad_bot_reg, pad_left_reg, pad_right_reg;
    logic [DIMW-1:0]  core_w_reg, core_h_reg, x_reg, y_reg;
    logic             pad_reg, up_reg, last_reg;

    logic             cfg_us_en;
    logic [ZNUMW-1:0] cfg_nz, cfg_idx_x, cfg_idx_y;
    logic [DIMW-1:0]  cfg_pad_top, cfg_pad_bot, cfg_pad_left, cfg_pad_right;
    logic [DIMW-1:0]  cfg_core_w, cfg_core_h;

    logic             abort_req;
`ifdef SDMA_SAP_US_ABORT_EN
    logic             aborted_reg;
    assign abort_req = i_sap_us_abort;
`else
    assign abort_req = 1'b0;
`endif

    logic in_load;
    assign in_load = (state_reg == LOAD);

    // During LOAD the live inputs feed the first beat; afterwards the latched copy does.
    always_comb begin
        if (in_load) begin
            cfg_us_en     = i_sap_us_upsampleen;
            cfg_nz        = i_sap_us_insertzeronum;
            cfg_idx_x     = i_sap_us_paddingen ? i_sap_us_upsampleidxx : '0;
            cfg_idx_y     = i_sap_us_paddingen ? i_sap_us_upsampleidxy : '0;
            cfg_pad_top   = i_sap_us_paddingen ? i_sap_us_padtop : '0;
            cfg_pad_bot   = i_sap_us_paddingen ? i_sap_us_padbottom : '0;
            cfg_pad_left  = i_sap_us_paddingen ? i_sap_us_padleft : '0;
            cfg_pad_right = i_sap_us_paddingen ? i_sap_us_padright : '0;
            cfg_core_w    = i_sap_us_corewidth;
            cfg_core_h    = i_sap_us_coreheight;
        end else begin
            cfg_us_en     = us_en_reg;
            cfg_nz        = nz_reg;
            cfg_idx_x     = idx_x_reg;
            cfg_idx_y     = idx_y_reg;
            cfg_pad_top   = pad_top_reg;
            cfg_pad_bot   = pad_bot_reg;
            cfg_pad_left  = pad_left_reg;
            cfg_pad_right = pad_right_reg;
            cfg_core_w    = core_w_reg;
            cfg_core_h    = core_h_reg;
        end
    end

    logic [SW-1:0] width_total, height_total, core_x_lo, core_x_hi, core_y_lo, core_y_hi;
    assign core_x_lo    = SW'(cfg_pad_left);
    assign core_x_hi    = core_x_lo + SW'(cfg_core_w);
    assign core_y_lo    = SW'(cfg_pad_top);
    assign core_y_hi    = core_y_lo + SW'(cfg_core_h);
    assign width_total  = core_x_hi + SW'(cfg_pad_right);
    assign height_total = core_y_hi + SW'(cfg_pad_bot);

    function automatic logic [ZNUMW-1:0] phase_step(input logic [ZNUMW-1:0] cnt,
                                                   input logic [ZNUMW-1:0] cnt_max);
        return (cnt == cnt_max) ? '0 : cnt + ZNUMW'(1);
    endfunction

    logic [SW-1:0]    x_ext, y_ext, x_next, y_next;
    logic [ZNUMW-1:0] xcnt_next, ycnt_next;
    logic             row_end, cur_core_row, pad_next, up_next, last_next;

    // Next beat position and phases; flags are derived from these so they line up with x/y.
    always_comb begin
        x_ext        = SW'(x_reg);
        y_ext        = SW'(y_reg);
        row_end      = (x_ext == width_total - SW'(1));
        cur_core_row = (y_ext >= core_y_lo) && (y_ext < core_y_hi);
        x_next       = '0;
        y_next       = '0;
        xcnt_next    = '0;
        ycnt_next    = '0;
        if (!in_load) begin
            x_next    = row_end ? '0 : x_ext + SW'(1);
            y_next    = row_end ? y_ext + SW'(1) : y_ext;
            xcnt_next = xcnt_reg;
            ycnt_next = ycnt_reg;
            if (!cfg_us_en) begin
                xcnt_next = '0;
                ycnt_next = '0;
            end else begin
                if (x_next == core_x_lo)
                    xcnt_next = '0;
                else if ((x_next > core_x_lo) && (x_next < core_x_hi))
                    xcnt_next = phase_step(xcnt_reg, cfg_nz);
                if (cur_core_row && (x_ext == core_x_hi - SW'(1)))
                    ycnt_next = phase_step(ycnt_reg, cfg_nz);
            end
        end
        pad_next  = (y_next < core_y_lo) || (y_next >= core_y_hi) ||
                    (x_next < core_x_lo) || (x_next >= core_x_hi);
        up_next   = cfg_us_en && !pad_next &&
                    !((xcnt_next == cfg_idx_x) && (ycnt_next == cfg_idx_y));
        last_next = (x_next == width_total - SW'(1)) && (y_next == height_total - SW'(1));
    end

    logic core_empty, beat_adv, beat_load, beat_clear;
    assign core_empty = (cfg_core_w == '0) || (cfg_core_h == '0);
    assign beat_adv   = (state_reg == SCAN) && vld_reg && i_sap_us_rdy;
    assign beat_load  = (in_load && !abort_req && !core_empty) ||
                        (beat_adv && !last_reg && !abort_req);
    assign beat_clear = (state_reg == SCAN) && (abort_req || (beat_adv && last_reg));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            vld_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef SDMA_SAP_US_ABORT_EN
            aborted_reg   <= 1'b0;
`endif
            us_en_reg     <= 1'b0;
            nz_reg        <= '0;
            idx_x_reg     <= '0;
            idx_y_reg     <= '0;
            pad_top_reg   <= '0;
            pad_bot_reg   <= '0;
            pad_left_reg  <= '0;
            pad_right_reg <= '0;
            core_w_reg    <= '0;
            core_h_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
`ifdef SDMA_SAP_US_ABORT_EN
            aborted_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (i_sap_us_start) begin
                        state_reg <= LOAD;
                        busy_reg  <= 1'b1;
                    end
                end
                LOAD: begin
                    us_en_reg     <= cfg_us_en;
                    nz_reg        <= cfg_nz;
                    idx_x_reg     <= cfg_idx_x;
                    idx_y_reg     <= cfg_idx_y;
                    pad_top_reg   <= cfg_pad_top;
                    pad_bot_reg   <= cfg_pad_bot;
                    pad_left_reg  <= cfg_pad_left;
                    pad_right_reg <= cfg_pad_right;
                    core_w_reg    <= cfg_core_w;
                    core_h_reg    <= cfg_core_h;
                    if (abort_req || core_empty) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
`ifdef SDMA_SAP_US_ABORT_EN
                        aborted_reg <= abort_req;
`endif
                    end else begin
                        state_reg <= SCAN;
                        vld_reg   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (beat_clear) begin
                        state_reg <= DONE;
                        vld_reg   <= 1'b0;
                        done_reg  <= 1'b1;
`ifdef SDMA_SAP_US_ABORT_EN
                        aborted_reg <= abort_req;
`endif
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_reg    <= '0;
            y_reg    <= '0;
            xcnt_reg <= '0;
            ycnt_reg <= '0;
            pad_reg  <= 1'b0;
            up_reg   <= 1'b0;
            last_reg <= 1'b0;
        end else if (beat_load) begin
            x_reg    <= x_next[DIMW-1:0];
            y_reg    <= y_next[DIMW-1:0];
            xcnt_reg <= xcnt_next;
            ycnt_reg <= ycnt_next;
            pad_reg  <= pad_next;
            up_reg   <= up_next;
            last_reg <= last_next;
        end else if (beat_clear) begin
            x_reg    <= '0;
            y_reg    <= '0;
            xcnt_reg <= '0;
            ycnt_reg <= '0;
            pad_reg  <= 1'b0;
            up_reg   <= 1'b0;
            last_reg <= 1'b0;
        end
    end

    assign o_sap_us_vld          = vld_reg;
    assign o_sap_us_x            = x_reg;
    assign o_sap_us_y            = y_reg;
    assign o_sap_us_paddingflag  = pad_reg;
    assign o_sap_us_upsampleflag = up_reg;
    assign o_sap_us_last         = last_reg;
    assign o_sap_us_busy         = busy_reg;
    assign o_sap_us_done         = done_reg;
`ifdef SDMA_SAP_US_ABORT_EN
    assign o_sap_us_aborted      = aborted_reg;
`endif

endmodule

// File: doc/sdma_sap_upsample_scanner.md
Name: sdma_sap_upsample_scanner

Overview:
- Sequencer that walks every position of a destination feature map in raster order: top/bottom/left/right padding rows and columns, plus the upsampled core region.
- Generates per-position upsample phase counters and the padding and upsample (zero-insertion) flags.
- Presents each position as one beat on a valid/ready stream towards the SAP write datapath.
- Sits between the SAP instruction decoder (configuration plus start) and the SAP output address/data generator.

Parameters:
- ZNUMW, 4, width of insert-zero count and of the phase counters (SDMA insert-zero-number width).
- DIMW, 12, width of the destination dimension, padding amount and coordinate fields.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_sap_us_start  in  1  start pulse; sampled only in IDLE
- i_sap_us_upsampleen  in  1  upsample enable
- i_sap_us_paddingen  in  1  padding enable
- i_sap_us_insertzeronum  in  ZNUMW  N, zeros inserted per source pixel; phase period is N+1
- i_sap_us_upsampleidxx  in  ZNUMW  x phase of the real pixel
- i_sap_us_upsampleidxy  in  ZNUMW  y phase of the real pixel
- i_sap_us_padtop, i_sap_us_padbottom, i_sap_us_padleft, i_sap_us_padright  in  DIMW each  padding amounts
- i_sap_us_corewidth, i_sap_us_coreheight  in  DIMW each  upsampled core size
- o_sap_us_vld  out  1  beat valid
- i_sap_us_rdy  in  1  downstream ready
- o_sap_us_x, o_sap_us_y  out  DIMW each  full-map coordinate
- o_sap_us_paddingflag  out  1  position lies in padding
- o_sap_us_upsampleflag  out  1  position is an inserted zero
- o_sap_us_last  out  1  final beat
- o_sap_us_busy  out  1  not IDLE
- o_sap_us_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- FSM states: IDLE, LOAD, SCAN, DONE.
- IDLE -> LOAD on start. Configuration is latched in LOAD. Start is ignored outside IDLE.
- LOAD -> DONE if corewidth==0 or coreheight==0; no beats are issued.
- LOAD -> SCAN otherwise. The first beat (x=0, y=0) asserts vld on the cycle after LOAD.
- Padding amounts are treated as 0 when paddingen=0.
- Total width W = padleft+corewidth+padright; total height H = padtop+coreheight+padbottom. Arithmetic is DIMW+1 bits, and the sum must not exceed 2^DIMW-1; this is the configuration's responsibility.
- All beat outputs are registered. They hold stable while vld=1 and rdy=0, and advance only on vld&rdy.
- x increments and wraps to 0 at W-1. On that wrap y increments.
- paddingflag = (y<padtop) | (y>=padtop+coreheight) | (x<padleft) | (x>=padleft+corewidth).
- xcnt resets to 0 at the first core column of every row. It increments per core column handshake and wraps N->0.
- ycnt is 0 at the first core row. It increments when leaving the last core column of a core row and wraps N->0.
- With upsampleen=0, both xcnt and ycnt are held at 0.
- idxx' = paddingen ? upsampleidxx : 0; idxy' likewise.
- upsampleflag = upsampleen & ~paddingflag & ~(xcnt==idxx' & ycnt==idxy').
- The flags are computed from next-state counters, so they align with the registered x/y (zero extra latency).
- last = (x==W-1 & y==H-1).
- On the handshake of the last beat: vld drops the next cycle and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in LOAD, SCAN and DONE.
- Throughput: one beat per cycle when rdy is held high.
- Reset mid-scan: immediate return to IDLE with all outputs 0. No done pulse.

Optional Feature:
- Macro: SDMA_SAP_US_ABORT_EN.
- When defined: adds input i_sap_us_abort (1 bit). Abort in LOAD or SCAN causes vld=0 the next cycle, even with an unaccepted beat pending, and a transition to DONE. done pulses one cycle, and the new output o_sap_us_aborted (1 bit) pulses in the same cycle. Abort in IDLE or DONE is ignored. Abort takes priority over a same-cycle handshake; that beat is still counted as accepted downstream.
- When undefined: neither port exists and the scan always runs to completion.

Test Plan:
- No padding, upsample N=1, idx=0, core 4x2, rdy=1 -> 8 beats in 8 consecutive cycles. upsampleflag pattern 0,1,0,1 on row 0 and 1,1,1,1 on row 1. last on beat 8. done one cycle after.
- paddingen=1, pad all sides 1, core 2x2, N=1, idxx=1, idxy=0 -> W=H=4, 16 beats, paddingflag on the 12 border beats. Core row 0 upsampleflag 1,0; core row 1 upsampleflag 1,1.
- upsampleen=0, core 3x3 -> 9 beats, upsampleflag always 0, xcnt and ycnt stay 0.
- Random rdy (about 50%) on a 5x3 map -> x, y and flags stable while stalled. Beat sequence identical to the rdy=1 run. No beat lost or duplicated.
- corewidth=0 -> no vld, done asserted 2 cycles after start. A start pulse while busy mid-scan has no effect.
- Reset asserted mid-scan at beat 5 -> all outputs 0 asynchronously. A new start after release scans from x=0, y=0. With SDMA_SAP_US_ABORT_EN, abort at beat 3 -> vld low the next cycle, and done and aborted pulse together.
